// File: rtl/uart_spbrg_if.sv
// Register/strobe bundle between the UART baud-rate generator and its host.
// The master side is the CPU/UART core; the slave side is uart_spbrg.
interface uart_spbrg_if;
  logic       sync;
  logic       brgh;
  logic       spbrg_reg_wr_en;
  logic [7:0] spbrg_reg_in;
  logic [7:0] spbrg_reg_out;
  logic       uart_tx_shift_en;

  modport master (
    output sync,
    output brgh,
    output spbrg_reg_wr_en,
    output spbrg_reg_in,
    input  spbrg_reg_out,
    input  uart_tx_shift_en
  );

  modport slave (
    input  sync,
    input  brgh,
    input  spbrg_reg_wr_en,
    input  spbrg_reg_in,
    output spbrg_reg_out,
    output uart_tx_shift_en
  );
endinterface

// File: rtl/uart_spbrg.sv
// UART baud-rate generator: SPBRG register plus a prescaled divider emitting a one-clock strobe
// every N*(SPBRG+1) clocks. Define UART_SPBRG_SYNC_EN to enable the sync-mode (N=4) rate.
module uart_spbrg (
  input  logic        clk,
  input  logic        rst,
  uart_spbrg_if.slave bus
);

  logic [7:0] spbrg;
  logic [5:0] uart_clk_count_prescaler;
  logic [7:0] uart_clk_count;
  logic       uart_tx_shift_en;
  logic [5:0] prescale_last;

`ifdef UART_SPBRG_SYNC_EN
  always_comb begin
    prescale_last = 6'd63;
    if (bus.sync) begin
      prescale_last = 6'd3;
    end else if (bus.brgh) begin
      prescale_last = 6'd15;
    end
  end
`else
  logic unused_sync;
  assign unused_sync = bus.sync;

  always_comb begin
    prescale_last = 6'd63;
    if (bus.brgh) begin
      prescale_last = 6'd15;
    end
  end
`endif

  // The >= compares keep the divider from overrunning when SPBRG or N shrink mid-period.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      spbrg                    <= 8'd0;
      uart_clk_count_prescaler <= 6'd0;
      uart_clk_count           <= 8'd0;
      uart_tx_shift_en         <= 1'b0;
    end else begin
      uart_tx_shift_en <= 1'b0;
      if (bus.spbrg_reg_wr_en) begin
        spbrg <= bus.spbrg_reg_in;
      end
      if (uart_clk_count_prescaler >= prescale_last) begin
        uart_clk_count_prescaler <= 6'd0;
        if (uart_clk_count >= spbrg) begin
          uart_clk_count   <= 8'd0;
          uart_tx_shift_en <= 1'b1;
        end else begin
          uart_clk_count <= uart_clk_count + 8'd1;
        end
      end else begin
        uart_clk_count_prescaler <= uart_clk_count_prescaler + 6'd1;
      end
    end
  end

  assign bus.spbrg_reg_out    = spbrg;
  assign bus.uart_tx_shift_en = uart_tx_shift_en;

endmodule

// File: tb/tb_uart_spbrg.sv
// Self-checking bench for uart_spbrg: directed period/write/reset scenarios, then randomized
// steady-state segments checked against a strobe-every-N*(SPBRG+1) reference.
module tb_uart_spbrg;

  logic clk;
  logic rst;
  int   checks;
  int   passes;

  uart_spbrg_if bus ();

  uart_spbrg dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference prescale: sync only counts when the build enables the sync-mode rate.
  function automatic int prescale(input bit s, input bit h);
    bit sync_en;
`ifdef UART_SPBRG_SYNC_EN
    sync_en = 1'b1;
`else
    sync_en = 1'b0;
`endif
    if (s && sync_en) return 4;
    return h ? 16 : 64;
  endfunction

  task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one rising edge, then sample the strobe 1ns later.
  task automatic apply_stimulus(input bit exp_strobe, input string tag);
    @(posedge clk);
    #1;
    check_output(tag, {7'd0, bus.uart_tx_shift_en}, {7'd0, exp_strobe});
  endtask

  task automatic write_spbrg(input logic [7:0] val, input bit exp_strobe, input string tag);
    bus.spbrg_reg_wr_en = 1'b1;
    bus.spbrg_reg_in    = val;
    apply_stimulus(exp_strobe, tag);
    bus.spbrg_reg_wr_en = 1'b0;
    check_output({tag, "_readback"}, bus.spbrg_reg_out, val);
  endtask

  initial begin
    int period;
    int s_val;
    checks = 0;
    passes = 0;
    rst                 = 1'b0;
    bus.sync            = 1'b0;
    bus.brgh            = 1'b0;
    bus.spbrg_reg_wr_en = 1'b0;
    bus.spbrg_reg_in    = 8'd0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_spbrg_out", bus.spbrg_reg_out, 8'd0);
    check_output("reset_strobe", {7'd0, bus.uart_tx_shift_en}, 8'd0);
    rst = 1'b1;

    // SPBRG=0, N=64: strobe after edges 64 and 128 only
    for (int e = 1; e <= 128; e++)
      apply_stimulus((e % 64) == 0, $sformatf("n64_s0_edge%0d", e));

    // SPBRG=1 written right after the strobe: next strobe 128 edges after edge 128
    write_spbrg(8'd1, 1'b0, "wr1_edge1");
    for (int e = 2; e <= 128; e++)
      apply_stimulus(e == 128, $sformatf("n64_s1_edge%0d", e));

    // Counters at 0, brgh=1 with SPBRG=1: period 32
    bus.brgh = 1'b1;
    for (int e = 1; e <= 32; e++)
      apply_stimulus(e == 32, $sformatf("n16_s1_edge%0d", e));

    // brgh=1, SPBRG=0 written right after strobe: period 16
    write_spbrg(8'd0, 1'b0, "wr0_edge1");
    for (int e = 2; e <= 16; e++)
      apply_stimulus(e == 16, $sformatf("n16_s0_edge%0d", e));

    // SPBRG=200, let the count reach 150, then drop SPBRG to 10
    write_spbrg(8'd200, 1'b0, "wr200_edge1");
    for (int e = 2; e <= 2400; e++)
      apply_stimulus(1'b0, "n16_s200_quiet");
    write_spbrg(8'd10, 1'b0, "wr10_edge2401");
    for (int e = 2402; e <= 2416 + 176; e++)
      apply_stimulus(e == 2416 || e == 2416 + 176, $sformatf("shrink_edge%0d", e));

    // Async reset mid-period clears strobe and readback immediately
    for (int e = 1; e <= 50; e++)
      apply_stimulus(1'b0, "pre_reset_quiet");
    #2;
    rst = 1'b0;
    #1;
    check_output("async_rst_strobe", {7'd0, bus.uart_tx_shift_en}, 8'd0);
    check_output("async_rst_spbrg", bus.spbrg_reg_out, 8'd0);
    for (int e = 1; e <= 20; e++)
      apply_stimulus(1'b0, "in_reset_quiet");
    rst = 1'b1;
    for (int e = 1; e <= 32; e++)
      apply_stimulus((e % 16) == 0, $sformatf("post_rst_edge%0d", e));

    // Randomized steady-state segments: strobe exactly on edges that are multiples of N*(S+1)
    for (int seg = 0; seg < 6; seg++) begin
      rst = 1'b0;
      bus.sync = 1'($urandom_range(0, 1));
      bus.brgh = 1'($urandom_range(0, 1));
      s_val    = int'($urandom_range(0, 5));
      @(posedge clk);
      #1;
      rst = 1'b1;
      period = prescale(bus.sync, bus.brgh) * (s_val + 1);
      write_spbrg(8'(s_val), 1'b0, $sformatf("rnd%0d_wr", seg));
      for (int e = 2; e <= 2 * period + 3; e++)
        apply_stimulus((e % period) == 0,
                       $sformatf("rnd%0d_sync%0b_brgh%0b_s%0d_edge%0d", seg, bus.sync, bus.brgh, s_val, e));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
